// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: steps one decoded instruction through
// register read, ALU execute and write-back, and maintains the PSR flags.
module alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        instr_op,
    input  logic [RA_W-1:0]   instr_rdest,
    input  logic [RA_W-1:0]   instr_rsrc,
    input  logic [7:0]        instr_imm,
    output logic [RA_W-1:0]   rf_raddr_a,
    output logic [RA_W-1:0]   rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [4:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [4:0]        alu_flags,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [4:0]        psr,
    output logic              done,
    output logic              illegal
);

    localparam logic [4:0] OP_ADDI   = 5'b00001;
    localparam logic [4:0] OP_ADDUI  = 5'b00011;
    localparam logic [4:0] OP_ADDCUI = 5'b00110;
    localparam logic [4:0] OP_ADDCI  = 5'b00111;
    localparam logic [4:0] OP_SUBI   = 5'b01001;
    localparam logic [4:0] OP_CMP    = 5'b01010;
    localparam logic [4:0] OP_CMPI   = 5'b01011;
    localparam logic [4:0] OP_CMPUI  = 5'b01100;
    localparam logic [4:0] OP_LSHI   = 5'b10010;
    localparam logic [4:0] OP_RSHI   = 5'b10100;
    localparam logic [4:0] OP_NOP    = 5'b10111;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state, state_next;
    logic [4:0]        op_q;
    logic [RA_W-1:0]   rdest_q, rsrc_q;
    logic [7:0]        imm_q;
    logic              is_imm, sign_ext, illegal_op, writes_rf;
    logic [DATA_W-1:0] ext_imm;

    // Operand and write-back qualifiers decoded from the latched opcode.
    always_comb begin
        is_imm    = 1'b0;
        sign_ext  = 1'b0;
        writes_rf = 1'b1;
        case (op_q)
            OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: begin
                is_imm   = 1'b1;
                sign_ext = 1'b1;
            end
            OP_ADDUI, OP_ADDCUI, OP_CMPUI, OP_LSHI, OP_RSHI: is_imm = 1'b1;
            default: ;
        endcase
        if (op_q == OP_CMP || op_q == OP_CMPI || op_q == OP_CMPUI || op_q == OP_NOP)
            writes_rf = 1'b0;
        illegal_op = (op_q[4:3] == 2'b11);
        if (illegal_op)
            writes_rf = 1'b0;
        ext_imm = sign_ext ? {{(DATA_W-8){imm_q[7]}}, imm_q} : {{(DATA_W-8){1'b0}}, imm_q};
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        rf_we       = 1'b0;
        illegal     = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_next = READ;
            end
            READ: state_next = EXEC;
            EXEC: state_next = WB;
            WB: begin
                done       = 1'b1;
                illegal    = illegal_op;
                rf_we      = writes_rf;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            rdest_q <= '0;
            rsrc_q  <= '0;
            imm_q   <= '0;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            psr     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && instr_valid) begin
                op_q    <= instr_op;
                rdest_q <= instr_rdest;
                rsrc_q  <= instr_rsrc;
                imm_q   <= instr_imm;
            end
            if (state == EXEC) begin
                alu_a  <= rf_rdata_a;
                alu_b  <= is_imm ? ext_imm : rf_rdata_b;
                alu_op <= illegal_op ? OP_NOP : op_q;
            end
            // Arithmetic ops own C/F/Z, compares own L/Z/N; other bits hold.
            if (state == WB && !illegal_op) begin
                if (op_q <= OP_SUBI) begin
                    psr[4] <= alu_flags[4];
                    psr[2] <= alu_flags[2];
                    psr[1] <= alu_flags[1];
                end else if (op_q >= OP_CMP && op_q <= OP_CMPUI) begin
                    psr[3] <= alu_flags[3];
                    psr[1] <= alu_flags[1];
                    psr[0] <= alu_flags[0];
                end
            end
        end
    end

    assign rf_raddr_a = rdest_q;
    assign rf_raddr_b = rsrc_q;
    assign rf_waddr   = rdest_q;
    assign rf_wdata   = alu_out;
    assign alu_cin    = psr[4];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural register file, ALU
// and an instruction-level reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [4:0]  instr_op = '0;
    logic [3:0]  instr_rdest = '0;
    logic [3:0]  instr_rsrc = '0;
    logic [7:0]  instr_imm = '0;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic [4:0]  alu_op, alu_flags, psr;
    logic [15:0] alu_a, alu_b, alu_out;
    logic        alu_cin, rf_we, done, illegal;

    alu_sequencer #(.DATA_W(16), .RA_W(4)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rdest(instr_rdest),
        .instr_rsrc(instr_rsrc), .instr_imm(instr_imm),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .psr(psr), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read register file with a preload port for the bench.
    logic [15:0] rf_mem [16];
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    always @(posedge clk) begin
        rf_rdata_a <= rf_mem[rf_raddr_a];
        rf_rdata_b <= rf_mem[rf_raddr_b];
        if (load_en)
            rf_mem[load_addr] <= load_data;
        else if (rf_we)
            rf_mem[rf_waddr] <= rf_wdata;
    end

    // Behavioural ALU: returns {C,L,F,Z,N, result}.
    function automatic logic [20:0] alu_model(input logic [4:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, f;
        s = '0; r = '0; c = 1'b0; f = 1'b0;
        if (op <= 5'd3) s = {1'b0, a} + {1'b0, b};
        else if (op <= 5'd7) s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        else if (op <= 5'd12) s = {1'b0, a} - {1'b0, b};
        if (op <= 5'd12) begin
            r = s[15:0];
            c = s[16];
            f = (op >= 5'd8) ? ((a[15] != b[15]) && (r[15] != a[15]))
                             : ((a[15] == b[15]) && (r[15] != a[15]));
        end else if (op == 5'd13) r = a & b;
        else if (op == 5'd14) r = a | b;
        else if (op == 5'd15) r = a ^ b;
        else if (op == 5'd16) r = ~a;
        else if (op == 5'd17 || op == 5'd18 || op == 5'd21) r = a << b[3:0];
        else if (op == 5'd19 || op == 5'd20) r = a >> b[3:0];
        else if (op == 5'd22) r = $signed(a) >>> b[3:0];
        return {c, (a < b), f, (r == 16'd0), ($signed(a) < $signed(b)), r};
    endfunction

    always_comb {alu_flags, alu_out} = alu_model(alu_op, alu_a, alu_b, alu_cin);

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  aop;
        logic        ill;
        logic [4:0]  psr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] mreg [16];
    logic [4:0]  mpsr = '0;
    logic [4:0]  psr_exp = '0;
    bit          psr_pending = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Instruction-level model: operands, result, write-back and PSR rules.
    function automatic exp_t predict(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [7:0] imm, input int acc);
        exp_t        e;
        logic [20:0] res;
        e.ill = (op >= 5'd24);
        e.aop = e.ill ? 5'd23 : op;
        e.a   = mreg[rd];
        if (op inside {5'd1, 5'd7, 5'd9, 5'd11})
            e.b = {{8{imm[7]}}, imm};
        else if (op inside {5'd3, 5'd6, 5'd12, 5'd18, 5'd20})
            e.b = {8'd0, imm};
        else
            e.b = mreg[rs];
        res     = alu_model(e.aop, e.a, e.b, mpsr[4]);
        e.we    = !e.ill && !(op inside {5'd10, 5'd11, 5'd12, 5'd23});
        e.waddr = rd;
        e.wdata = res[15:0];
        e.psr   = mpsr;
        if (!e.ill && op <= 5'd9) begin
            e.psr[4] = res[20]; e.psr[2] = res[18]; e.psr[1] = res[17];
        end else if (op >= 5'd10 && op <= 5'd12) begin
            e.psr[3] = res[19]; e.psr[1] = res[17]; e.psr[0] = res[16];
        end
        e.acc = acc;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge with
    // instr_valid still high.
    task automatic applyStimulus(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                 input logic [7:0] imm, input bit track, output int acc);
        exp_t e;
        int   n;
        instr_op = op; instr_rdest = rd; instr_rsrc = rs; instr_imm = imm;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                $display("[TB] FAIL accept_timeout actual=no_accept required=accept_within_20");
                failures++;
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "[TB] accept timeout");
            end
        end
        acc = cyc + 1;
        if (track) begin
            e = predict(op, rd, rs, imm, acc);
            q.push_back(e);
            mpsr = e.psr;
            if (e.we) mreg[rd] = e.wdata;
        end
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (psr_pending) begin
            checkOutput("psr", {27'd0, psr}, {27'd0, psr_exp});
            psr_pending = 0;
        end
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=done required=no_done");
            end else begin
                mon_e = q.pop_front();
                checkOutput("done_cycle", cyc, mon_e.acc + 2);
                checkOutput("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
                checkOutput("rf_we", {31'd0, rf_we}, {31'd0, mon_e.we});
                if (mon_e.we) begin
                    checkOutput("rf_waddr", {28'd0, rf_waddr}, {28'd0, mon_e.waddr});
                    checkOutput("rf_wdata", {16'd0, rf_wdata}, {16'd0, mon_e.wdata});
                end
                checkOutput("alu_op", {27'd0, alu_op}, {27'd0, mon_e.aop});
                checkOutput("alu_a", {16'd0, alu_a}, {16'd0, mon_e.a});
                checkOutput("alu_b", {16'd0, alu_b}, {16'd0, mon_e.b});
                psr_exp = mon_e.psr;
                psr_pending = 1;
            end
        end else begin
            checkOutput("idle_pulses", {30'd0, rf_we, illegal}, 32'd0);
        end
    end

    int acc0, acc1, acc2, acc_x, n;
    logic [15:0] v;

    initial begin
        #1 reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v = (i == 1) ? 16'h0005 : (i == 2) ? 16'h0007 : (i == 3) ? 16'h0000 :
                (i == 4) ? 16'h0003 : (i == 5) ? 16'h0009 : 16'($urandom);
            mreg[i] = v;
            load_en = 1'b1; load_addr = 4'(i); load_data = v;
        end
        @(negedge clk);
        load_en = 1'b0;
        checkOutput("reset_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("reset_psr", {27'd0, psr}, 32'd0);
        checkOutput("reset_alu", {alu_a, alu_b}, 32'd0);
        checkOutput("reset_alu_op", {27'd0, alu_op}, 32'd0);
        checkOutput("reset_pulses", {29'd0, done, rf_we, illegal}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed sequence
        applyStimulus(5'd0, 4'd1, 4'd2, 8'h00, 1, acc0);   // ADD r1,r2
        instr_valid = 1'b0;
        applyStimulus(5'd9, 4'd3, 4'd0, 8'hFF, 1, acc0);   // SUBI r3,-1
        instr_valid = 1'b0;
        applyStimulus(5'd3, 4'd6, 4'd0, 8'h80, 1, acc0);   // ADDUI r6,0x80
        instr_valid = 1'b0;
        applyStimulus(5'd10, 4'd4, 4'd5, 8'h00, 1, acc0);  // CMP r4,r5
        instr_valid = 1'b0;
        applyStimulus(5'd26, 4'd7, 4'd8, 8'h00, 1, acc0);  // illegal
        instr_valid = 1'b0;

        // Back-to-back accepts with instr_valid held high
        applyStimulus(5'd0, 4'd1, 4'd2, 8'h00, 1, acc0);
        applyStimulus(5'd0, 4'd2, 4'd1, 8'h00, 1, acc1);
        applyStimulus(5'd0, 4'd9, 4'd1, 8'h00, 1, acc2);
        instr_valid = 1'b0;
        checkOutput("accept_spacing_1", acc1 - acc0, 32'd4);
        checkOutput("accept_spacing_2", acc2 - acc1, 32'd4);
        repeat (4) @(negedge clk);

        // Reset during EXEC aborts the instruction
        applyStimulus(5'd4, 4'd1, 4'd2, 8'h00, 0, acc_x);
        instr_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("abort_psr", {27'd0, psr}, 32'd0);
        checkOutput("abort_ready", {31'd0, instr_ready}, 32'd1);
        mpsr = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(5'd4, 4'd1, 4'd2, 8'h00, 1, acc0);   // ADDC after abort
        instr_valid = 1'b0;

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            applyStimulus(5'($urandom_range(0, 31)), 4'($urandom), 4'($urandom),
                          8'($urandom), 1, acc0);
            if ($urandom_range(0, 1) == 1) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        instr_valid = 1'b0;

        n = 0;
        while ((q.size() != 0 || psr_pending) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that accepts one decoded instruction at a time and sequences a single 16-bit ALU and a dual-read/single-write register file through operand read, execute and write-back. It forms immediate operands, drives the ALU opcode and carry-in, writes results back, and keeps the 5-bit processor status register (PSR) of flags. It sits between the instruction decoder (upstream, valid/ready handshake) and the ALU/register file (downstream). Throughput is one instruction per 4 cycles.

## Interface
- DATA_W, 16, datapath width
- RA_W, 4, register-file address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  decoder has an instruction
- instr_ready  out  1  sequencer can accept; high only in IDLE
- instr_op  in  5  opcode (ADD=00000 … NOP=10111, encoding below)
- instr_rdest  in  RA_W  destination/first-operand register
- instr_rsrc  in  RA_W  source register (ignored for immediate ops)
- instr_imm  in  8  immediate (ignored for register ops)
- rf_raddr_a / rf_raddr_b  out  RA_W  read addresses (Rdest / Rsrc)
- rf_rdata_a / rf_rdata_b  in  DATA_W  read data, valid one clock after address
- alu_op  out  5  opcode to ALU
- alu_a / alu_b  out  DATA_W  Rdest value / Rsrc value or extended immediate
- alu_cin  out  1  PSR.C, for ADDC/ADDCU/ADDCUI/ADDCI
- alu_out  in  DATA_W  ALU result (combinational)
- alu_flags  in  5  {C,L,F,Z,N} from ALU
- rf_we  out  1  write-enable pulse
- rf_waddr  out  RA_W  write address
- rf_wdata  out  DATA_W  write data
- psr  out  5  {C,L,F,Z,N} status register
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse with done for opcodes 11000–11111

## Operation
- Opcodes: ADD 00000, ADDI 00001, ADDU 00010, ADDUI 00011, ADDC 00100, ADDCU 00101, ADDCUI 00110, ADDCI 00111, SUB 01000, SUBI 01001, CMP 01010, CMPI 01011, CMPUI 01100, AND 01101, OR 01110, XOR 01111, NOT 10000, LSH 10001, LSHI 10010, RSH 10011, RSHI 10100, ALSH 10101, ARSH 10110, NOP 10111.
- Immediate ops: ADDI, ADDUI, ADDCUI, ADDCI, SUBI, CMPI, CMPUI, LSHI, RSHI. Sign-extend imm[7] for ADDI, ADDCI, SUBI, CMPI; zero-extend for the rest.
- States: IDLE → READ → EXEC → WB → IDLE. Illegal opcodes follow the same path.
- IDLE: instr_ready=1; on instr_valid&instr_ready, latch op/rdest/rsrc/imm, go READ.
- READ: rf_raddr_a=rdest, rf_raddr_b=rsrc; go EXEC.
- EXEC: register alu_a=rf_rdata_a, alu_b=rf_rdata_b or extended imm, alu_op=latched op (illegal → NOP); go WB.
- WB: capture alu_out/alu_flags; done=1; rf_we=1 with rf_waddr=rdest, rf_wdata=alu_out, except CMP, CMPI, CMPUI, NOP, illegal (rf_we=0).
- PSR update in WB: ADD…SUBI (00000–01001) load C, F, Z from alu_flags; CMP/CMPI/CMPUI load L, Z, N; logic, shift, NOP and illegal leave PSR unchanged. Bits not loaded are held.
- alu_cin = PSR.C at all times; PSR written in WB is visible to the next instruction.

## Timing
- Reset (asynchronous): state=IDLE, instr_ready=1, psr=0, alu_a/alu_b/alu_op=0, rf_we=0, done=0, illegal=0, latched fields=0. instr_valid is ignored while reset is high.
- Accept edge = cycle 0. READ is cycle 1, EXEC cycle 2, WB cycle 3 (done, rf_we). IDLE is cycle 4, and the earliest next accept is the cycle-4 edge.
- instr_valid held high continuously gives exactly one accept per 4 cycles. Fields must be stable only on the accept edge.
- Reset asserted mid-instruction aborts it: no rf_we, no done, and PSR is cleared.
- Writes to the register just read: the register file returns the old value in READ. WB and the next READ never overlap, so no forwarding is needed.

## Test plan
- r1=0x0005, r2=0x0007, ADD rdest=1 rsrc=2 → cycle 3: rf_we=1, waddr=1, wdata=0x000C, done=1; PSR.C/F/Z=0.
- r3=0x0000, SUBI rdest=3 imm=0xFF → alu_b=0xFFFF, wdata=0x0001; ADDUI imm=0x80 → alu_b=0x0080.
- r4=0x0003, r5=0x0009, CMP rdest=4 rsrc=5 → rf_we=0, PSR.L=1, N=1, Z=0; C/F unchanged from prior value.
- Opcode 11010 → done=1, illegal=1, rf_we=0, psr unchanged, alu_op=10111.
- instr_valid held high for 3 ADDs → accepts at cycles 0, 4, 8; done at 3, 7, 11; instr_ready low in cycles 1–3.
- Reset asserted in EXEC → no rf_we, no done; psr=0, instr_ready=1 immediately. The next instruction completes normally.
